// File: rtl/operation_proj_param.sv
// Parametrised projection operator: on a rising ST edge, snapshots IN[SEL]
// and presents it on RES after LAT cycles, using the ST/RD start/ready handshake.
module operation_proj_param #(
  parameter int BW  = 16,
  parameter int NIN = 2,
  parameter int SW  = 1,
  parameter int LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ST,
  input  logic [SW-1:0]     SEL,
  input  logic [NIN*BW-1:0] IN,
  output logic              RD,
  output logic [BW-1:0]     RES,
  output logic              ERR
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [SW:0]   NIN_W = (SW+1)'(NIN);
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic          st_old;
  logic [CW-1:0] cnt;
  logic [BW-1:0] snap;
  logic          snap_err;

  logic          start;
  logic          sel_err;
  logic [BW-1:0] sel_word;

  assign start   = ST & ~st_old;
  assign sel_err = ({1'b0, SEL} >= NIN_W);

  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      if (SEL == SW'(k)) sel_word = IN[k*BW +: BW];
    end
  end

  // st_old tracks ST even during reset, so ST held high across reset release is not a start.
  always_ff @(posedge CLK) begin
    st_old <= ST;
    if (RST) begin
      state    <= IDLE;
      RD       <= 1'b1;
      RES      <= '0;
      ERR      <= 1'b0;
      cnt      <= '0;
      snap     <= '0;
      snap_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap     <= sel_err ? '0 : sel_word;
            snap_err <= sel_err;
            RD       <= 1'b0;
            ERR      <= 1'b0;
            cnt      <= CNT_INIT;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            RES   <= snap;
            ERR   <= snap_err;
            RD    <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
